// File: rtl/pkg_resp.sv
// pkg_resp: shared data-phase {resp, ready} encodings.
package pkg_resp;

  localparam logic [1:0] RespSuccess = 2'b01;
  localparam logic [1:0] RespWait    = 2'b00;
  localparam logic [1:0] RespError1  = 2'b10;
  localparam logic [1:0] RespError2  = 2'b11;

endpackage

// File: rtl/pkg_trans.sv
// pkg_trans: shared bus transfer-type encodings.
package pkg_trans;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

endpackage

// File: rtl/D_FF.sv
// D_FF: register with asynchronous active-low reset to zero and write enable.
module D_FF #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // Load d when enabled; reset clears the register immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bus_error_slave.sv
// bus_error_slave: default slave that answers every accepted NONSEQ/SEQ
// transfer with a two-cycle error response after WaitCycles wait states.
// Define BUS_ERROR_SLAVE_LOG_EN to build the first-error log, error counter
// and interrupt; without it those outputs are tied to zero.
//
// Handshake: a transfer is taken when sel_i, ready_i and an active transfer
// type coincide while the response FSM is idle or in its last error cycle
// (ready_o high); ready_o low holds the master in its data phase.
module bus_error_slave
  import pkg_trans::*;
  import pkg_resp::*;
#(
  parameter int DWidth     = 32,
  parameter int AWidth     = 32,
  parameter int WaitCycles = 0,
  parameter int CntWidth   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              ready_i,
  input  logic [1:0]        trans_i,
  input  logic [AWidth-1:0] addr_i,
  input  logic              write_i,
  input  logic              clr_i,
  output logic [DWidth-1:0] rdata_o,
  output logic              resp_o,
  output logic              ready_o,
  output logic              err_valid_o,
  output logic [AWidth-1:0] err_addr_o,
  output logic              err_write_o,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StError1 = 2'd2,
    StError2 = 2'd3
  } state_e;

  localparam logic [7:0] WaitLoad = 8'(WaitCycles);

  logic [1:0] state_bits;
  state_e     state;
  state_e     state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       take;
  logic       enter_err1;
  logic [1:0] resp_bits;

  assign state = state_e'(state_bits);

  // Only idle and the final error cycle present ready_o=1, so only they take a transfer.
  assign take = sel_i & ready_i & ((trans_i == TransNonseq) | (trans_i == TransSeq))
              & ((state == StIdle) | (state == StError2));

  // Next-state and wait-counter logic for the response sequence.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      StIdle, StError2: begin
        state_next = StIdle;
        if (take) begin
          if (WaitCycles > 0) begin
            state_next = StWait;
            wait_next  = WaitLoad;
          end else begin
            state_next = StError1;
          end
        end
      end
      StWait: begin
        wait_next = wait_cnt - 8'd1;
        if (wait_cnt <= 8'd1) begin
          state_next = StError1;
        end
      end
      StError1: state_next = StError2;
      default:  state_next = StIdle;
    endcase
  end

  // Moore decode of {resp, ready} from the current state.
  always_comb begin
    resp_bits = RespSuccess;
    case (state)
      StIdle:   resp_bits = RespSuccess;
      StWait:   resp_bits = RespWait;
      StError1: resp_bits = RespError1;
      StError2: resp_bits = RespError2;
      default:  resp_bits = RespSuccess;
    endcase
  end

  assign {resp_o, ready_o} = resp_bits;
  assign rdata_o           = '0;
  assign enter_err1        = (state_next == StError1);

  D_FF #(.Width(2)) u_state (
    .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(state_next), .q(state_bits)
  );

  D_FF #(.Width(8)) u_wait_cnt (
    .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(wait_next), .q(wait_cnt)
  );

`ifdef BUS_ERROR_SLAVE_LOG_EN
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [AWidth-1:0]   lat_addr;
  logic [AWidth-1:0]   cap_addr;
  logic                lat_write;
  logic                cap_write;
  logic                capture;
  logic                valid_next;
  logic [CntWidth-1:0] cnt_next;

  D_FF #(.Width(AWidth)) u_lat_addr (
    .clk(clk_i), .rst_n(rst_ni), .en(take), .d(addr_i), .q(lat_addr)
  );

  D_FF #(.Width(1)) u_lat_write (
    .clk(clk_i), .rst_n(rst_ni), .en(take), .d(write_i), .q(lat_write)
  );

  // Log update: a new error beats a coincident clear; with no wait states the
  // transfer is still on addr_i/write_i when the error starts.
  always_comb begin
    cap_addr   = take ? addr_i : lat_addr;
    cap_write  = take ? write_i : lat_write;
    capture    = enter_err1 & (~err_valid_o | clr_i);
    valid_next = err_valid_o;
    cnt_next   = err_cnt_o;
    if (clr_i) begin
      valid_next = 1'b0;
      cnt_next   = '0;
    end
    if (enter_err1) begin
      valid_next = 1'b1;
      if (clr_i) begin
        cnt_next = CntOne;
      end else if (err_cnt_o != '1) begin
        cnt_next = err_cnt_o + CntOne;
      end
    end
  end

  D_FF #(.Width(1)) u_err_valid (
    .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(valid_next), .q(err_valid_o)
  );

  D_FF #(.Width(AWidth)) u_err_addr (
    .clk(clk_i), .rst_n(rst_ni), .en(capture), .d(cap_addr), .q(err_addr_o)
  );

  D_FF #(.Width(1)) u_err_write (
    .clk(clk_i), .rst_n(rst_ni), .en(capture), .d(cap_write), .q(err_write_o)
  );

  D_FF #(.Width(CntWidth)) u_err_cnt (
    .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(cnt_next), .q(err_cnt_o)
  );

  D_FF #(.Width(1)) u_irq (
    .clk(clk_i), .rst_n(rst_ni), .en(1'b1), .d(valid_next), .q(irq_o)
  );
`else
  logic unused_log;

  assign unused_log  = ^{addr_i, write_i, clr_i};
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_write_o = 1'b0;
  assign err_cnt_o   = '0;
  assign irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_error_slave.sv
// tb_bus_error_slave: three bus_error_slave instances (no wait states, three
// wait states, 2-bit counter) driven from shared inputs and compared every
// cycle against a timeline model of the response and error log.
module tb_bus_error_slave;

  localparam int NDut = 3;

`ifdef BUS_ERROR_SLAVE_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  typedef struct packed {
    logic        resp;
    logic        ready;
    logic        err_valid;
    logic        err_write;
    logic        irq;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;
    logic [31:0] rdata;
  } obs_t;

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic sel, rdy, write, clr;
  logic [1:0]  trans;
  logic [31:0] addr;

  always #5 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic resp0, ready0, ev0, ew0, irq0; logic [31:0] ea0, rd0; logic [7:0] ec0;
  logic resp1, ready1, ev1, ew1, irq1; logic [31:0] ea1, rd1; logic [7:0] ec1;
  logic resp2, ready2, ev2, ew2, irq2; logic [31:0] ea2, rd2; logic [1:0] ec2;

  bus_error_slave #(.DWidth(32), .AWidth(32), .WaitCycles(0), .CntWidth(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .ready_i(rdy), .trans_i(trans),
    .addr_i(addr), .write_i(write), .clr_i(clr), .rdata_o(rd0), .resp_o(resp0),
    .ready_o(ready0), .err_valid_o(ev0), .err_addr_o(ea0), .err_write_o(ew0),
    .err_cnt_o(ec0), .irq_o(irq0)
  );

  bus_error_slave #(.DWidth(32), .AWidth(32), .WaitCycles(3), .CntWidth(8)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .ready_i(rdy), .trans_i(trans),
    .addr_i(addr), .write_i(write), .clr_i(clr), .rdata_o(rd1), .resp_o(resp1),
    .ready_o(ready1), .err_valid_o(ev1), .err_addr_o(ea1), .err_write_o(ew1),
    .err_cnt_o(ec1), .irq_o(irq1)
  );

  bus_error_slave #(.DWidth(32), .AWidth(32), .WaitCycles(0), .CntWidth(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .ready_i(rdy), .trans_i(trans),
    .addr_i(addr), .write_i(write), .clr_i(clr), .rdata_o(rd2), .resp_o(resp2),
    .ready_o(ready2), .err_valid_o(ev2), .err_addr_o(ea2), .err_write_o(ew2),
    .err_cnt_o(ec2), .irq_o(irq2)
  );

  obs_t obs [NDut];

  always_comb begin
    obs[0] = '{resp: resp0, ready: ready0, err_valid: ev0, err_write: ew0, irq: irq0,
               err_addr: ea0, err_cnt: ec0, rdata: rd0};
    obs[1] = '{resp: resp1, ready: ready1, err_valid: ev1, err_write: ew1, irq: irq1,
               err_addr: ea1, err_cnt: ec1, rdata: rd1};
    obs[2] = '{resp: resp2, ready: ready2, err_valid: ev2, err_write: ew2, irq: irq2,
               err_addr: ea2, err_cnt: {6'b0, ec2}, rdata: rd2};
  end

  // ---------------- scoreboard counters ----------------
  int n_checks;
  int n_errors;
  logic [1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is described by the edge at which its last transfer was
  // taken; the response shape follows from the distance to that edge.
  int          edge_n;
  bit          acc_any  [NDut];
  int          acc_edge [NDut];
  logic [31:0] acc_addr [NDut];
  logic        acc_wr   [NDut];
  bit          m_valid  [NDut];
  logic [31:0] m_addr   [NDut];
  logic        m_wr     [NDut];
  int          m_cnt    [NDut];

  function automatic int w_of(int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int cnt_max(int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDut; i++) begin
      acc_any[i] = 1'b0; acc_edge[i] = 0; acc_addr[i] = '0; acc_wr[i] = 1'b0;
      m_valid[i] = 1'b0; m_addr[i] = '0; m_wr[i] = 1'b0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit req;
    bit enter;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req = sel && rdy && (trans == 2'b10 || trans == 2'b11);
    for (int i = 0; i < NDut; i++) begin
      // a transfer is taken only once the previous response has reached its last cycle
      if (req && (!acc_any[i] || (edge_n - 1 - acc_edge[i]) >= w_of(i) + 1)) begin
        acc_any[i]  = 1'b1;
        acc_edge[i] = edge_n;
        acc_addr[i] = addr;
        acc_wr[i]   = write;
      end
      enter = acc_any[i] && (edge_n - acc_edge[i] == w_of(i));
      if (enter) begin
        if (!m_valid[i] || clr) begin
          m_valid[i] = 1'b1;
          m_addr[i]  = acc_addr[i];
          m_wr[i]    = acc_wr[i];
        end
        if (clr) m_cnt[i] = 1;
        else if (m_cnt[i] < cnt_max(i)) m_cnt[i] = m_cnt[i] + 1;
      end else if (clr) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 0;
      end
    end
  endfunction

  function automatic obs_t model_expect(int i);
    obs_t e;
    int   k;
    e       = '0;
    e.ready = 1'b1;
    if (acc_any[i]) begin
      k = edge_n - acc_edge[i];
      if (k < w_of(i)) begin
        e.ready = 1'b0;
      end else if (k == w_of(i)) begin
        e.resp  = 1'b1;
        e.ready = 1'b0;
      end else if (k == w_of(i) + 1) begin
        e.resp  = 1'b1;
      end
    end
    if (LogEn) begin
      e.err_valid = m_valid[i];
      e.irq       = m_valid[i];
      e.err_addr  = m_addr[i];
      e.err_write = m_wr[i];
      e.err_cnt   = 8'(m_cnt[i]);
    end
    return e;
  endfunction

  task automatic check_all();
    obs_t e;
    obs_t o;
    for (int i = 0; i < NDut; i++) begin
      e = model_expect(i);
      o = obs[i];
      check_eq($sformatf("d%0d_resp@%0d", i, edge_n), 32'(o.resp), 32'(e.resp));
      check_eq($sformatf("d%0d_ready@%0d", i, edge_n), 32'(o.ready), 32'(e.ready));
      check_eq($sformatf("d%0d_rdata@%0d", i, edge_n), o.rdata, e.rdata);
      check_eq($sformatf("d%0d_err_valid@%0d", i, edge_n), 32'(o.err_valid), 32'(e.err_valid));
      check_eq($sformatf("d%0d_irq@%0d", i, edge_n), 32'(o.irq), 32'(e.irq));
      check_eq($sformatf("d%0d_err_addr@%0d", i, edge_n), o.err_addr, e.err_addr);
      check_eq($sformatf("d%0d_err_write@%0d", i, edge_n), 32'(o.err_write), 32'(e.err_write));
      check_eq($sformatf("d%0d_err_cnt@%0d", i, edge_n), 32'(o.err_cnt), 32'(e.err_cnt));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic s, input logic r, input logic [1:0] t,
                       input logic [31:0] a, input logic w, input logic c);
    sel = s; rdy = r; trans = t; addr = a; write = w; clr = c;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic settle_clear();
    idle_in();
    repeat (6) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] pat [4];
    logic [3:0] p;
    n_checks = 0;
    n_errors = 0;
    edge_n   = 0;
    model_reset();
    rst_n = 1'b0;
    idle_in();
    repeat (3) step();
    check_eq("rst_resp", 32'(resp0), 32'd0);
    check_eq("rst_ready", 32'(ready0), 32'd1);
    check_eq("rst_rdata", rd0, 32'd0);
    check_eq("rst_err_cnt", 32'(ec0), 32'd0);
    check_eq("rst_err_valid", 32'(ev0), 32'd0);
    rst_n = 1'b1;
    step();

    // single error, no wait states
    drive(1'b1, 1'b1, 2'b10, 32'h1000_0040, 1'b1, 1'b0);
    step();
    check_eq("t1_rr0", 32'({resp0, ready0}), 32'(2'b10));
    idle_in();
    step();
    check_eq("t1_rr1", 32'({resp0, ready0}), 32'(2'b11));
    step();
    check_eq("t1_rr2", 32'({resp0, ready0}), 32'(2'b01));
    check_eq("t1_err_addr", ea0, LogEn ? 32'h1000_0040 : 32'h0);
    check_eq("t1_err_write", 32'(ew0), LogEn ? 32'd1 : 32'd0);
    check_eq("t1_err_cnt", 32'(ec0), LogEn ? 32'd1 : 32'd0);
    check_eq("t1_irq", 32'(irq0), LogEn ? 32'd1 : 32'd0);

    // three wait states before the error
    settle_clear();
    exp_q = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
    drive(1'b1, 1'b1, 2'b11, 32'h0000_2000, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step();
      idle_in();
      check_eq($sformatf("t2_rr%0d", j), 32'({resp1, ready1}), 32'(exp_q.pop_front()));
    end

    // transfers that must not be taken
    settle_clear();
    pat = '{4'b1100, 4'b1101, 4'b1010, 4'b0111};
    for (int j = 0; j < 4; j++) begin
      p = pat[j];
      drive(p[3], p[2], p[1:0], 32'h0000_3000, 1'b0, 1'b0);
      step();
      check_eq($sformatf("t3_rr%0d", j), 32'({resp0, ready0}), 32'(2'b01));
      check_eq($sformatf("t3_cnt%0d", j), 32'(ec0), 32'd0);
    end

    // back-to-back errors, second taken in the final error cycle
    settle_clear();
    drive(1'b1, 1'b1, 2'b10, 32'h10, 1'b0, 1'b0);
    step();
    check_eq("t4_rr0", 32'({resp0, ready0}), 32'(2'b10));
    idle_in();
    step();
    check_eq("t4_rr1", 32'({resp0, ready0}), 32'(2'b11));
    drive(1'b1, 1'b1, 2'b10, 32'h20, 1'b1, 1'b0);
    step();
    check_eq("t4_rr2", 32'({resp0, ready0}), 32'(2'b10));
    idle_in();
    step();
    check_eq("t4_rr3", 32'({resp0, ready0}), 32'(2'b11));
    step();
    check_eq("t4_rr4", 32'({resp0, ready0}), 32'(2'b01));
    check_eq("t4_err_addr", ea0, LogEn ? 32'h10 : 32'h0);
    check_eq("t4_err_cnt", 32'(ec0), LogEn ? 32'd2 : 32'd0);

    // counter saturation, then clear coinciding with a new error
    settle_clear();
    drive(1'b1, 1'b1, 2'b10, 32'h40, 1'b0, 1'b0);
    repeat (9) step();
    idle_in();
    repeat (3) step();
    check_eq("t5_cnt_sat", 32'(ec2), LogEn ? 32'd3 : 32'd0);
    check_eq("t5_cnt_wide", 32'(ec0), LogEn ? 32'd5 : 32'd0);
    drive(1'b1, 1'b1, 2'b10, 32'h30, 1'b1, 1'b1);
    step();
    idle_in();
    check_eq("t5_clr_cnt", 32'(ec2), LogEn ? 32'd1 : 32'd0);
    check_eq("t5_clr_valid", 32'(ev2), LogEn ? 32'd1 : 32'd0);
    check_eq("t5_clr_addr", ea2, LogEn ? 32'h30 : 32'h0);

    // reset while waiting
    settle_clear();
    drive(1'b1, 1'b1, 2'b10, 32'h50, 1'b1, 1'b0);
    step();
    idle_in();
    check_eq("t6_wait", 32'({resp1, ready1}), 32'(2'b00));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6_rr", 32'({resp1, ready1}), 32'(2'b01));
    check_eq("t6_valid1", 32'(ev1), 32'd0);
    check_eq("t6_cnt1", 32'(ec1), 32'd0);
    check_eq("t6_valid0", 32'(ev0), 32'd0);
    check_eq("t6_cnt0", 32'(ec0), 32'd0);
    check_eq("t6_irq0", 32'(irq0), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      sel   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 4) != 0);
      trans = 2'($urandom_range(0, 3));
      addr  = $urandom;
      write = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_error_slave.md
BUS_ERROR_SLAVE -- requirements
Module: bus_error_slave

Interface
REQ-001 SHALL have parameter DWidth, default 32: read data width.
REQ-002 SHALL have parameter AWidth, default 32: address width.
REQ-003 SHALL have parameter WaitCycles, default 0, legal 0..255: wait states inserted before the error response.
REQ-004 SHALL have parameter CntWidth, default 8: error counter width.
REQ-005 SHALL have port clk_i  input  1: single clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have ports sel_i, ready_i  input  1 each: slave select; bus-level ready, which qualifies the address phase.
REQ-008 SHALL have port trans_i  input  2: transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-009 SHALL have ports addr_i  input  AWidth and write_i  input  1: address-phase address and direction.
REQ-010 SHALL have port clr_i  input  1: clear the error log.
REQ-011 SHALL have ports rdata_o  output  DWidth, resp_o  output  1 and ready_o  output  1: data-phase response.
REQ-012 SHALL have ports err_valid_o  output  1, err_addr_o  output  AWidth, err_write_o  output  1, err_cnt_o  output  CntWidth and irq_o  output  1: error log.

Function
REQ-013 SHALL drive rdata_o constant zero.
REQ-014 SHALL accept a transfer when sel_i=1, ready_i=1 and trans_i is NONSEQ or SEQ; IDLE and BUSY SHALL NOT be accepted.
REQ-015 SHALL implement a Moore FSM whose {resp_o, ready_o} is: StIdle 01 (SUCCESS), StWait 00, StError1 10 (ERROR_1), StError2 11 (ERROR_2).
REQ-016 SHALL transition StIdle -> StWait on an accepted transfer when WaitCycles>0, or StIdle -> StError1 when WaitCycles=0.
REQ-017 SHALL hold StWait for exactly WaitCycles cycles using a down-counter loaded on acceptance, then enter StError1.
REQ-018 SHALL transition StError1 -> StError2 unconditionally.
REQ-019 SHALL transition StError2 -> StIdle, unless a transfer is accepted in that cycle, in which case it SHALL follow REQ-016 (back-to-back errors, no idle gap).
REQ-020 SHALL give an error response whose first ERROR_1 cycle is 1+WaitCycles cycles after acceptance.
REQ-021 SHALL latch addr_i and write_i on acceptance into internal registers.
REQ-022 SHALL, on entry to StError1 with err_valid_o=0, set err_valid_o=1 and copy the latched address and direction to err_addr_o and err_write_o; later errors SHALL NOT overwrite them.
REQ-023 SHALL increment err_cnt_o on every StError1 entry, saturating at all-ones.
REQ-024 SHALL, on clr_i=1, clear err_valid_o and err_cnt_o the next cycle; if clr_i coincides with StError1 entry, the new error SHALL win (err_valid_o=1, err_cnt_o=1, new address captured).
REQ-025 SHALL drive irq_o = err_valid_o, registered.

Reset
REQ-026 SHALL, on rst_ni=0, asynchronously force StIdle, wait counter 0 and all log registers 0, so outputs read resp_o=0, ready_o=1, rdata_o=0 and log outputs 0.
REQ-027 SHALL return to StIdle on reset asserted mid-response, without completing ERROR_2.

Configuration
REQ-028 SHALL, with BUS_ERROR_SLAVE_LOG_EN defined, implement REQ-021..REQ-025.
REQ-029 SHALL, without BUS_ERROR_SLAVE_LOG_EN, omit the log registers, tie err_valid_o, err_addr_o, err_write_o, err_cnt_o and irq_o to 0, and keep the response FSM unchanged.

Structure
REQ-030 SHALL use the shared pkg_trans (transfer-type encodings) and pkg_resp (SUCCESS/ERROR_1/ERROR_2 {resp,ready} encodings); the FSM state enum SHALL be local.
REQ-031 SHALL hold all state in instances of the existing D_FF sub-module (asynchronous active-low reset, write enable); no other sub-module.

Verification
REQ-032 SHALL verify: WaitCycles=0, NONSEQ to addr 0x1000_0040 -> next cycles {resp,ready}=10 then 11 then 01; err_addr_o=0x1000_0040, err_cnt_o=1.
REQ-033 SHALL verify: WaitCycles=3, SEQ accepted -> 3 cycles of 00, then 10, then 11.
REQ-034 SHALL verify: IDLE, BUSY, or NONSEQ with ready_i=0 -> resp_o/ready_o remain 01, err_cnt_o unchanged.
REQ-035 SHALL verify: back-to-back NONSEQ at 0x10 and 0x20, the second accepted during StError2 -> 10,11,10,11; err_addr_o=0x10, err_cnt_o=2.
REQ-036 SHALL verify: CntWidth=2, 5 errors -> err_cnt_o=3; clr_i pulsed in the same cycle as a StError1 entry -> err_cnt_o=1, err_valid_o=1.
REQ-037 SHALL verify: rst_ni dropped during StWait -> immediate 01 and log zero; built without BUS_ERROR_SLAVE_LOG_EN -> log outputs always 0.
